// File: rtl/sensor_pkg.sv
// Shared types and constants for the sensor UART framer.
`timescale 1ns/1ps
package sensor_pkg;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_SEQ,
        ST_LEN,
        ST_PAYLOAD,
        ST_CSUM
    } framer_state_t;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
    // SYNC + SEQ + LEN + CSUM wrapped around every payload
    localparam int PKT_OVERHEAD = 4;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock frame FIFO; head word is read combinationally from storage.
`timescale 1ns/1ps
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   i_CLK,
    input  logic                   i_RSTN,
    input  logic                   i_PUSH,
    input  logic                   i_POP,
    input  logic [WIDTH-1:0]       i_DATA,
    output logic [WIDTH-1:0]       o_DATA,
    output logic                   o_FULL,
    output logic                   o_EMPTY,
    output logic [$clog2(DEPTH):0] o_LEVEL
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
    localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [AW:0]      w_level;

    // Pointers carry one extra bit so full and empty are distinguishable
    always_ff @(posedge i_CLK or negedge i_RSTN) begin
        if (!i_RSTN) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (i_PUSH) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (i_POP)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge i_CLK) begin
        if (i_PUSH) r_mem[r_wr_ptr[AW-1:0]] <= i_DATA;
    end

    assign w_level = r_wr_ptr - r_rd_ptr;
    assign o_LEVEL = w_level;
    assign o_FULL  = (w_level == FULL_LVL);
    assign o_EMPTY = (w_level == '0);
    assign o_DATA  = r_mem[r_rd_ptr[AW-1:0]];
endmodule

// File: rtl/sensor_uart_framer.sv
// Buffers whole sensor frames and serialises them as SYNC/SEQ/LEN/payload/CSUM
// packets onto a registered valid/ready byte port.
//   state   | meaning
//   IDLE    | waiting for enable and a buffered frame
//   SYNC    | loading, then presenting SYNC_BYTE
//   SEQ     | presenting sequence number
//   LEN     | presenting payload length
//   PAYLOAD | presenting payload bytes, frame MSB first
//   CSUM    | presenting checksum (zero-sum over SEQ..CSUM)
`timescale 1ns/1ps
module sensor_uart_framer
    import sensor_pkg::*;
#(
    parameter int         NUM_CH       = 3,
    parameter int         SAMPLE_BYTES = 3,
    parameter int         FIFO_DEPTH   = 4,
    parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEFAULT
) (
    input  logic                              i_CLK,
    input  logic                              i_RSTN,
    input  logic [NUM_CH*SAMPLE_BYTES*8-1:0]  i_FRAME,
    input  logic                              i_FRAME_VALID,
    input  logic                              i_ENABLE,
    input  logic                              i_CLR,
    output logic [7:0]                        o_TX_DATA,
    output logic                              o_TX_VALID,
    input  logic                              i_TX_READY,
    output logic [$clog2(FIFO_DEPTH):0]       o_FIFO_LEVEL,
    output logic                              o_OVERFLOW,
    output logic [7:0]                        o_DROP_COUNT,
    output logic                              o_BUSY
);
    localparam int         FW       = NUM_CH*SAMPLE_BYTES*8;
    localparam logic [7:0] LEN      = 8'(NUM_CH*SAMPLE_BYTES);
    localparam logic [7:0] LAST_IDX = LEN - 8'd1;

    framer_state_t r_state, w_state_nxt;
    logic [FW-1:0] w_head, r_shift;
    logic [7:0]    r_tx_data, w_tx_data_nxt;
    logic [7:0]    r_seq, r_acc, w_acc_nxt, r_cnt, w_cnt_nxt, w_sum, r_drop_cnt;
    logic          r_tx_valid, w_tx_valid_nxt, r_ovf;
    logic          w_full, w_empty, w_push, w_pop, w_drop, w_hs, w_shift_en, w_seq_inc;

    // A full FIFO still accepts a frame when the head is popped in the same cycle
    assign w_push = i_FRAME_VALID & (~w_full | w_pop);
    assign w_drop = i_FRAME_VALID & w_full & ~w_pop;
    assign w_hs   = r_tx_valid & i_TX_READY;
    assign w_sum  = r_acc + r_tx_data;

    sync_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .i_CLK   (i_CLK),
        .i_RSTN  (i_RSTN),
        .i_PUSH  (w_push),
        .i_POP   (w_pop),
        .i_DATA  (i_FRAME),
        .o_DATA  (w_head),
        .o_FULL  (w_full),
        .o_EMPTY (w_empty),
        .o_LEVEL (o_FIFO_LEVEL)
    );

    always_ff @(posedge i_CLK or negedge i_RSTN) begin
        if (!i_RSTN) r_state <= ST_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_pop          = 1'b0;
        w_tx_valid_nxt = r_tx_valid;
        w_tx_data_nxt  = r_tx_data;
        w_acc_nxt      = r_acc;
        w_cnt_nxt      = r_cnt;
        w_shift_en     = 1'b0;
        w_seq_inc      = 1'b0;
        case (r_state)
            ST_IDLE: if (i_ENABLE && !w_empty) begin
                w_state_nxt = ST_SYNC;
                w_pop       = 1'b1;
                w_acc_nxt   = 8'd0;
            end
            ST_SYNC: if (!r_tx_valid) begin
                w_tx_valid_nxt = 1'b1;
                w_tx_data_nxt  = SYNC_BYTE;
            end else if (w_hs) begin
                w_state_nxt   = ST_SEQ;
                w_tx_data_nxt = r_seq;
            end
            ST_SEQ: if (w_hs) begin
                w_state_nxt   = ST_LEN;
                w_tx_data_nxt = LEN;
                w_acc_nxt     = w_sum;
            end
            ST_LEN: if (w_hs) begin
                w_state_nxt   = ST_PAYLOAD;
                w_tx_data_nxt = r_shift[FW-1 -: 8];
                w_shift_en    = 1'b1;
                w_cnt_nxt     = 8'd0;
                w_acc_nxt     = w_sum;
            end
            ST_PAYLOAD: if (w_hs) begin
                w_acc_nxt = w_sum;
                if (r_cnt == LAST_IDX) begin
                    w_state_nxt   = ST_CSUM;
                    w_tx_data_nxt = ~w_sum + 8'd1;
                end else begin
                    w_cnt_nxt     = r_cnt + 8'd1;
                    w_tx_data_nxt = r_shift[FW-1 -: 8];
                    w_shift_en    = 1'b1;
                end
            end
            ST_CSUM: if (w_hs) begin
                w_state_nxt    = ST_IDLE;
                w_tx_valid_nxt = 1'b0;
                w_seq_inc      = 1'b1;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_CLK or negedge i_RSTN) begin
        if (!i_RSTN) begin
            r_tx_valid <= 1'b0;
            r_tx_data  <= 8'd0;
            r_shift    <= '0;
            r_acc      <= 8'd0;
            r_cnt      <= 8'd0;
            r_seq      <= 8'd0;
        end else begin
            r_tx_valid <= w_tx_valid_nxt;
            r_tx_data  <= w_tx_data_nxt;
            r_acc      <= w_acc_nxt;
            r_cnt      <= w_cnt_nxt;
            if (w_pop)           r_shift <= w_head;
            else if (w_shift_en) r_shift <= r_shift << 8;
            if (w_seq_inc)       r_seq <= r_seq + 8'd1;
        end
    end

    // Clear takes priority, but a drop in the same cycle is still recorded
    always_ff @(posedge i_CLK or negedge i_RSTN) begin
        if (!i_RSTN) begin
            r_ovf      <= 1'b0;
            r_drop_cnt <= 8'd0;
        end else if (i_CLR) begin
            r_ovf      <= w_drop;
            r_drop_cnt <= {7'd0, w_drop};
        end else if (w_drop) begin
            r_ovf <= 1'b1;
            if (r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
        end
    end

    assign o_TX_DATA    = r_tx_data;
    assign o_TX_VALID   = r_tx_valid;
    assign o_OVERFLOW   = r_ovf;
    assign o_DROP_COUNT = r_drop_cnt;
    assign o_BUSY       = (r_state != ST_IDLE);
endmodule
